parity_frame_rx: RTL

- Serial receiver/checker for the team's parity-protected bit stream; it is the receiving end of the serial parity generator.
- Accepts one bit per enabled clock: start bit (0), DATA_W data bits LSB first, one parity bit, stop bit (1).
- Tracks running parity with a single state bit, the same way the generator does.
- Delivers the parallel word with a one-cycle valid strobe plus parity-error and framing-error flags to downstream logic.

---
 rtl/parity_frame_rx.sv | 120 ++++++++++++
 1 files changed

// File: rtl/parity_frame_rx.sv
// rtl/parity_frame_rx.sv - serial parity-protected frame receiver/checker
module parity_frame_rx #(
    parameter int DATA_W     = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              x,
    input  logic              en,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              par_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DATA   = 3'd1,
        ST_PARITY = 3'd2,
        ST_STOP   = 3'd3,
        ST_BREAK  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              par_q, par_d;
    logic              perr_q, perr_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              par_err_q, par_err_d;
    logic              frame_err_q, frame_err_d;
    logic [DATA_W:0]   shift_in;

    // LSB-first reception: each new bit enters at the MSB and moves down.
    assign shift_in = {x, shift_q};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            par_q       <= 1'b0;
            perr_q      <= 1'b0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            par_q       <= par_d;
            perr_q      <= perr_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            par_err_q   <= par_err_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        par_d       = par_q;
        perr_d      = perr_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        par_err_d   = par_err_q;
        frame_err_d = frame_err_q;
        if (en) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!x) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                        par_d   = 1'b0;
                    end
                end
                ST_DATA: begin
                    shift_d = shift_in[DATA_W:1];
                    par_d   = par_q ^ x;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    perr_d  = (par_q ^ x) != PARITY_ODD;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    data_d      = shift_q;
                    par_err_d   = perr_q;
                    frame_err_d = !x;
                    valid_d     = 1'b1;
                    state_d     = x ? ST_IDLE : ST_BREAK;
                end
                ST_BREAK: begin
                    // Stuck-low line: wait for it to return high before hunting for a start bit.
                    if (x) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign par_err   = par_err_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
